// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the PainterEngine GPU DMA blocks: state encoding,
// error causes, page size and the fixed AXI attribute values.
package painterengine_gpu_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } dma_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PARAM   = 2'd1,
    ERR_BUS     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } dma_err_e;

  localparam int unsigned PAGE_BYTES           = 4096;
  localparam int unsigned AXI_ID_WIDTH         = 4;
  localparam logic [1:0]  AXI_BURST_INCR       = 2'b01;
  localparam logic [3:0]  AXI_CACHE_MODIFIABLE = 4'b0010;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// Combinational burst sizer: the largest INCR burst that respects MAX_BURST,
// the 4 KB page boundary and the beats still left in the transfer.
module painterengine_gpu_dma_burst_calc
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 32
) (
  input  logic [31:0] address_i,
  input  logic [31:0] remaining_i,
  output logic [8:0]  burst_o
);

  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [12:0] pageBytes;
  logic [31:0] pageBeats;
  logic [31:0] capped;
  logic        unusedBits;

  // Address is beat-aligned, so the byte distance to the page end divides exactly.
  always_comb begin
    pageBytes = 13'(PAGE_BYTES) - {1'b0, address_i[11:0]};
    pageBeats = {19'd0, pageBytes} >> BEAT_SHIFT;
    capped    = min32(32'(MAX_BURST), pageBeats);
    capped    = min32(capped, remaining_i);
    burst_o   = capped[8:0];
  end

  assign unusedBits = ^{address_i[31:12], capped[31:9]};

endmodule

// File: rtl/painterengine_gpu_dma_reader_mc.sv
// Multi-channel AXI4 read DMA: fetches a linear buffer in page/MAX_BURST
// bounded INCR bursts and steers each beat to one consumer port.
module painterengine_gpu_dma_reader_mc
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNELS      = 4,
  parameter int MAX_BURST     = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                             i_wire_clock,
  input  logic                             i_wire_reset,
  input  logic                             i_wire_start,
  input  logic [$clog2(CHANNELS)-1:0]      i_wire_channel,
  input  logic [31:0]                      i_wire_address,
  input  logic [31:0]                      i_wire_length,
  output logic                             o_wire_busy,
  output logic                             o_wire_done,
  output logic                             o_wire_error,
  output logic [1:0]                       o_wire_error_code,
  output logic [CHANNELS*DATA_WIDTH-1:0]   o_wire_data,
  output logic [CHANNELS-1:0]              o_wire_data_valid,
  input  logic [CHANNELS-1:0]              i_wire_data_next,
  output logic [AXI_ID_WIDTH-1:0]          o_wire_M_AXI_ARID,
  output logic [31:0]                      o_wire_M_AXI_ARADDR,
  output logic [7:0]                       o_wire_M_AXI_ARLEN,
  output logic [2:0]                       o_wire_M_AXI_ARSIZE,
  output logic [1:0]                       o_wire_M_AXI_ARBURST,
  output logic                             o_wire_M_AXI_ARLOCK,
  output logic [3:0]                       o_wire_M_AXI_ARCACHE,
  output logic [2:0]                       o_wire_M_AXI_ARPROT,
  output logic [3:0]                       o_wire_M_AXI_ARQOS,
  output logic                             o_wire_M_AXI_ARVALID,
  input  logic                             i_wire_M_AXI_ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]          i_wire_M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]            i_wire_M_AXI_RDATA,
  input  logic [1:0]                       i_wire_M_AXI_RRESP,
  input  logic                             i_wire_M_AXI_RLAST,
  input  logic                             i_wire_M_AXI_RVALID,
  output logic                             o_wire_M_AXI_RREADY
);

  localparam int CH_W       = $clog2(CHANNELS);
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BYTES);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  dma_state_e               state_q, state_d;
  dma_err_e                 errCode_q, errCode_d;
  logic [CH_W-1:0]          channel_q, channel_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              length_q, length_d;
  logic [31:0]              offset_q, offset_d;
  logic [8:0]               lastBeat_q, lastBeat_d;
  logic [8:0]               beatCnt_q, beatCnt_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;

  logic        startable, busy, misaligned, isLastBeat;
  logic        arHs, rHs, rReady;
  logic [8:0]  burstBeats, calcBurst;
  logic [31:0] nextOffset, nextAddr, calcAddr, calcRemaining;
  logic        unusedBits;

  assign startable  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign busy       = (state_q == ST_ADDR) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign misaligned = |(i_wire_address & 32'(BYTES - 1));
  assign isLastBeat = (beatCnt_q == lastBeat_q);
  assign arHs       = (state_q == ST_ADDR) && i_wire_M_AXI_ARREADY;
  assign rHs        = i_wire_M_AXI_RVALID && rReady;

  assign burstBeats = lastBeat_q + 9'd1;
  assign nextOffset = offset_q + {23'd0, burstBeats};
  assign nextAddr   = addr_q + ({23'd0, burstBeats} << BEAT_SHIFT);

  // One sizer serves both the first burst (from the start inputs) and later ones.
  assign calcAddr      = startable ? i_wire_address : nextAddr;
  assign calcRemaining = startable ? i_wire_length : (length_q - nextOffset);

  painterengine_gpu_dma_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) u_burst_calc (
    .address_i   (calcAddr),
    .remaining_i (calcRemaining),
    .burst_o     (calcBurst)
  );

  always_comb begin
    state_d    = state_q;
    errCode_d  = errCode_q;
    channel_d  = channel_q;
    addr_d     = addr_q;
    length_d   = length_q;
    offset_d   = offset_q;
    lastBeat_d = lastBeat_q;
    beatCnt_d  = beatCnt_q;
    wd_d       = wd_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_wire_start) begin
          channel_d = i_wire_channel;
          addr_d    = i_wire_address;
          length_d  = i_wire_length;
          offset_d  = 32'd0;
          beatCnt_d = 9'd0;
          wd_d      = '0;
          if (misaligned || (i_wire_length == 32'd0)) begin
            state_d   = ST_ERROR;
            errCode_d = ERR_PARAM;
          end else begin
            state_d    = ST_ADDR;
            errCode_d  = ERR_NONE;
            lastBeat_d = calcBurst - 9'd1;
          end
        end
      end
      ST_ADDR: begin
        if (arHs) begin
          state_d   = ST_READ;
          beatCnt_d = 9'd0;
        end
      end
      ST_READ: begin
        if (rHs) begin
          // An early RLAST has already closed the burst, so there is nothing to drain.
          if (i_wire_M_AXI_RRESP[1] || (i_wire_M_AXI_RLAST != isLastBeat)) begin
            errCode_d = ERR_BUS;
            state_d   = (isLastBeat || i_wire_M_AXI_RLAST) ? ST_ERROR : ST_DRAIN;
            beatCnt_d = beatCnt_q + 9'd1;
          end else if (isLastBeat) begin
            offset_d = nextOffset;
            if (nextOffset == length_q) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_ADDR;
              addr_d     = nextAddr;
              lastBeat_d = calcBurst - 9'd1;
            end
          end else begin
            beatCnt_d = beatCnt_q + 9'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (rHs) begin
          if (i_wire_M_AXI_RLAST || isLastBeat) begin
            state_d = ST_ERROR;
          end else begin
            beatCnt_d = beatCnt_q + 9'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (busy) begin
      if (arHs || rHs) begin
        wd_d = '0;
      end else begin
        wd_d = wd_q + 1'b1;
        if (wd_q == WD_LAST) begin
          state_d   = ST_ERROR;
          errCode_d = ERR_TIMEOUT;
        end
      end
    end
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q    <= ST_IDLE;
      errCode_q  <= ERR_NONE;
      channel_q  <= '0;
      addr_q     <= 32'd0;
      length_q   <= 32'd0;
      offset_q   <= 32'd0;
      lastBeat_q <= 9'd0;
      beatCnt_q  <= 9'd0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      errCode_q  <= errCode_d;
      channel_q  <= channel_d;
      addr_q     <= addr_d;
      length_q   <= length_d;
      offset_q   <= offset_d;
      lastBeat_q <= lastBeat_d;
      beatCnt_q  <= beatCnt_d;
      wd_q       <= wd_d;
    end
  end

  // Zero-latency steering: R beats go straight to the selected port, never buffered.
  always_comb begin
    o_wire_data       = '0;
    o_wire_data_valid = '0;
    rReady            = 1'b0;
    if (state_q == ST_READ) begin
      rReady = i_wire_data_next[channel_q];
      for (int c = 0; c < CHANNELS; c++) begin
        if (channel_q == CH_W'(c)) begin
          o_wire_data[c*DATA_WIDTH +: DATA_WIDTH] = i_wire_M_AXI_RDATA;
          o_wire_data_valid[c]                    = i_wire_M_AXI_RVALID;
        end
      end
    end else if (state_q == ST_DRAIN) begin
      rReady = 1'b1;
    end
  end

  assign o_wire_busy       = busy;
  assign o_wire_done       = (state_q == ST_DONE);
  assign o_wire_error      = (state_q == ST_ERROR);
  assign o_wire_error_code = errCode_q;

  assign o_wire_M_AXI_ARID    = '0;
  assign o_wire_M_AXI_ARADDR  = addr_q;
  assign o_wire_M_AXI_ARLEN   = lastBeat_q[7:0];
  assign o_wire_M_AXI_ARSIZE  = 3'(BEAT_SHIFT);
  assign o_wire_M_AXI_ARBURST = AXI_BURST_INCR;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = AXI_CACHE_MODIFIABLE;
  assign o_wire_M_AXI_ARPROT  = 3'd0;
  assign o_wire_M_AXI_ARQOS   = 4'd0;
  assign o_wire_M_AXI_ARVALID = (state_q == ST_ADDR);
  assign o_wire_M_AXI_RREADY  = rReady;

  assign unusedBits = ^{i_wire_M_AXI_RID, i_wire_M_AXI_RRESP[0], lastBeat_q[8]};

endmodule

// File: tb/tb_painterengine_gpu_dma_reader_mc.sv
// Bench for the multi-channel read DMA: a small AXI slave that returns
// address-derived data, a per-cycle port monitor and a table of transfers.
module tb_painterengine_gpu_dma_reader_mc;

  localparam int DW = 32;
  localparam int CH = 4;
  localparam int MB = 16;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      chan;
  logic [31:0]     addr, len;
  logic            busy, done, error;
  logic [1:0]      errCode;
  logic [CH*DW-1:0] data;
  logic [CH-1:0]   dataValid, dataNext;
  logic [3:0]      arId, arCache, arQos, rId;
  logic [31:0]     arAddr;
  logic [7:0]      arLen;
  logic [2:0]      arSize, arProt;
  logic [1:0]      arBurst, rResp;
  logic            arLock, arValid, arReady, rLast, rValid, rReady;
  logic [DW-1:0]   rData;

  always #5 clk = ~clk;

  painterengine_gpu_dma_reader_mc #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .MAX_BURST(MB), .TIMEOUT_WIDTH(TW)
  ) dut (
    .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start),
    .i_wire_channel(chan), .i_wire_address(addr), .i_wire_length(len),
    .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(error),
    .o_wire_error_code(errCode), .o_wire_data(data),
    .o_wire_data_valid(dataValid), .i_wire_data_next(dataNext),
    .o_wire_M_AXI_ARID(arId), .o_wire_M_AXI_ARADDR(arAddr),
    .o_wire_M_AXI_ARLEN(arLen), .o_wire_M_AXI_ARSIZE(arSize),
    .o_wire_M_AXI_ARBURST(arBurst), .o_wire_M_AXI_ARLOCK(arLock),
    .o_wire_M_AXI_ARCACHE(arCache), .o_wire_M_AXI_ARPROT(arProt),
    .o_wire_M_AXI_ARQOS(arQos), .o_wire_M_AXI_ARVALID(arValid),
    .i_wire_M_AXI_ARREADY(arReady), .i_wire_M_AXI_RID(rId),
    .i_wire_M_AXI_RDATA(rData), .i_wire_M_AXI_RRESP(rResp),
    .i_wire_M_AXI_RLAST(rLast), .i_wire_M_AXI_RVALID(rValid),
    .o_wire_M_AXI_RREADY(rReady)
  );

  typedef struct {
    logic [1:0]       ch;
    logic [31:0]      addr;
    logic [31:0]      len;
    int               errBeat;
    bit               bp;
    logic             expDone;
    logic             expError;
    logic [1:0]       expCode;
    int               expArs;
    logic [2:0][31:0] arAddr;
    logic [2:0][7:0]  arLen;
    int               expBeats;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  // Slave / monitor state shared with the main sequence.
  bit          arReadyEn = 1'b1;
  int          errBeat   = -1;
  bit          bpEn      = 1'b0;
  logic [1:0]  curCh     = 2'd0;
  int          cycle     = 0;
  int          hsTotal   = 0;
  int          strayCnt  = 0;
  int          rreadyBad = 0;
  int          drainBad  = 0;
  logic [31:0] arAddrLog[$];
  logic [7:0]  arLenLog[$];
  logic [31:0] chData[$];
  bit          active    = 1'b0;
  bit          drainExp  = 1'b0;
  bit          pendAr    = 1'b0;
  bit          pendR     = 1'b0;
  logic [31:0] bAddr;
  logic [7:0]  bLen;
  int          bIdx;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearLogs();
    arAddrLog.delete();
    arLenLog.delete();
    chData.delete();
    strayCnt  = 0;
    rreadyBad = 0;
    drainBad  = 0;
    hsTotal   = 0;
  endtask

  task automatic pulseStart(input logic [1:0] c, input logic [31:0] a, input logic [31:0] l);
    @(negedge clk);
    start = 1'b1; chan = c; addr = a; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput({name, "_idle_wait"}, 32'd0, 32'd1);
  endtask

  task automatic setVec(input int i, input logic [1:0] c, input logic [31:0] a, input logic [31:0] l,
                        input int eb, input bit bp, input logic ed, input logic ee, input logic [1:0] ec,
                        input int nAr, input logic [31:0] a0, input logic [7:0] l0,
                        input logic [31:0] a1, input logic [7:0] l1,
                        input logic [31:0] a2, input logic [7:0] l2, input int beats);
    vecs[i].ch = c;        vecs[i].addr = a;      vecs[i].len = l;
    vecs[i].errBeat = eb;  vecs[i].bp = bp;
    vecs[i].expDone = ed;  vecs[i].expError = ee; vecs[i].expCode = ec;
    vecs[i].expArs = nAr;
    vecs[i].arAddr[0] = a0; vecs[i].arLen[0] = l0;
    vecs[i].arAddr[1] = a1; vecs[i].arLen[1] = l1;
    vecs[i].arAddr[2] = a2; vecs[i].arLen[2] = l2;
    vecs[i].expBeats = beats;
  endtask

  task automatic applyStimulus(input int i);
    string n;
    n = $sformatf("vec%0d", i);
    clearLogs();
    curCh   = vecs[i].ch;
    errBeat = vecs[i].errBeat;
    bpEn    = vecs[i].bp;
    pulseStart(vecs[i].ch, vecs[i].addr, vecs[i].len);
    waitIdle(n);
    checkOutput({n, "_done"}, 32'(done), 32'(vecs[i].expDone));
    checkOutput({n, "_error"}, 32'(error), 32'(vecs[i].expError));
    checkOutput({n, "_code"}, 32'(errCode), 32'(vecs[i].expCode));
    checkOutput({n, "_ar_count"}, 32'(arAddrLog.size()), 32'(vecs[i].expArs));
    for (int k = 0; k < vecs[i].expArs && k < arAddrLog.size(); k++) begin
      checkOutput($sformatf("%s_araddr%0d", n, k), arAddrLog[k], vecs[i].arAddr[k]);
      checkOutput($sformatf("%s_arlen%0d", n, k), 32'(arLenLog[k]), 32'(vecs[i].arLen[k]));
    end
    checkOutput({n, "_beats"}, 32'(chData.size()), 32'(vecs[i].expBeats));
    begin
      int bad = 0;
      for (int k = 0; k < chData.size(); k++)
        if (chData[k] !== pattern(vecs[i].addr + 32'(4 * k))) bad++;
      checkOutput({n, "_data_order"}, 32'(bad), 32'd0);
    end
    checkOutput({n, "_stray_valid"}, 32'(strayCnt), 32'd0);
    checkOutput({n, "_rready_mirror"}, 32'(rreadyBad), 32'd0);
    checkOutput({n, "_drain"}, 32'(drainBad), 32'd0);
    errBeat = -1;
    bpEn    = 1'b0;
  endtask

  // AXI slave plus monitor: drives at the falling edge, records at falling edge + 1.
  initial begin : slave
    arReady = 1'b0; rValid = 1'b0; rData = '0; rLast = 1'b0; rResp = 2'b00;
    rId = 4'd0; dataNext = '0;
    forever begin
      @(negedge clk);
      cycle++;
      if (pendR) begin
        if (bIdx == errBeat) drainExp = 1'b1;
        if (bIdx == int'(bLen)) begin
          active   = 1'b0;
          drainExp = 1'b0;
        end
        bIdx++;
      end
      if (pendAr) begin
        active = 1'b1;
        bAddr  = arAddr;
        bLen   = arLen;
        bIdx   = 0;
      end
      arReady  = arReadyEn;
      rValid   = active;
      rData    = pattern(bAddr + 32'(4 * bIdx));
      rLast    = active && (bIdx == int'(bLen));
      rResp    = (active && bIdx == errBeat) ? 2'b10 : 2'b00;
      dataNext = 4'($urandom);
      dataNext[curCh] = bpEn ? (cycle % 3 != 0) : 1'b1;
      #1;
      if (rst) begin
        active = 1'b0; drainExp = 1'b0; pendAr = 1'b0; pendR = 1'b0;
      end else begin
        pendAr = arValid && arReady;
        pendR  = rValid && rReady;
        if (pendAr) begin
          arAddrLog.push_back(arAddr);
          arLenLog.push_back(arLen);
        end
        for (int c = 0; c < CH; c++)
          if (c != int'(curCh) && (dataValid[c] || data[c*DW +: DW] != '0)) strayCnt++;
        if (active && !drainExp) begin
          if (rReady !== dataNext[curCh]) rreadyBad++;
          if (dataValid[curCh] !== rValid || data[int'(curCh)*DW +: DW] !== rData) strayCnt++;
        end
        if (!active && dataValid != '0) strayCnt++;
        if (active && drainExp && (!rReady || dataValid != '0)) drainBad++;
        if (pendR && !drainExp) chData.push_back(data[int'(curCh)*DW +: DW]);
        if (pendR) hsTotal++;
      end
    end
  end

  initial begin : guard
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : main
    //      idx ch addr          len eb  bp done err code nAr  ar0          len0   ar1          len1   ar2          len2  beats
    setVec(0, 2, 32'h0000_1000,  8, -1, 0, 1, 0, 2'd0, 1, 32'h0000_1000, 8'd7,  32'h0,       8'd0,  32'h0,       8'd0, 8);
    setVec(1, 1, 32'h0000_1FF0, 10, -1, 0, 1, 0, 2'd0, 2, 32'h0000_1FF0, 8'd3,  32'h0000_2000, 8'd5, 32'h0,       8'd0, 10);
    setVec(2, 3, 32'h0000_3000, 40, -1, 1, 1, 0, 2'd0, 3, 32'h0000_3000, 8'd15, 32'h0000_3040, 8'd15, 32'h0000_3080, 8'd7, 40);
    setVec(3, 0, 32'h0000_1002,  4, -1, 0, 0, 1, 2'd1, 0, 32'h0,         8'd0,  32'h0,       8'd0,  32'h0,       8'd0, 0);
    setVec(4, 0, 32'h0000_1000,  0, -1, 0, 0, 1, 2'd1, 0, 32'h0,         8'd0,  32'h0,       8'd0,  32'h0,       8'd0, 0);
    setVec(5, 1, 32'h0000_4000, 16,  3, 0, 0, 1, 2'd2, 1, 32'h0000_4000, 8'd15, 32'h0,       8'd0,  32'h0,       8'd0, 4);
    setVec(6, 2, 32'h0000_5000,  5, -1, 0, 1, 0, 2'd0, 1, 32'h0000_5000, 8'd4,  32'h0,       8'd0,  32'h0,       8'd0, 5);

    rst = 1'b1; start = 1'b0; chan = 2'd0; addr = 32'd0; len = 32'd0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    checkOutput("reset_code", 32'(errCode), 32'd0);
    checkOutput("reset_arvalid", 32'(arValid), 32'd0);
    checkOutput("reset_araddr", arAddr, 32'd0);
    checkOutput("reset_arlen", 32'(arLen), 32'd0);
    checkOutput("reset_rready", 32'(rReady), 32'd0);
    checkOutput("reset_valid", 32'(dataValid), 32'd0);
    checkOutput("reset_data_or", 32'(|data), 32'd0);
    checkOutput("arsize", 32'(arSize), 32'd2);
    checkOutput("arburst", 32'(arBurst), 32'd1);
    checkOutput("arcache", 32'(arCache), 32'd2);
    @(negedge clk);
    rst = 1'b0;

    // Start latency and done timing on a two-beat transfer.
    begin
      bit found = 1'b0;
      clearLogs();
      curCh = 2'd0;
      pulseStart(2'd0, 32'h0000_6000, 32'd2);
      #2;
      checkOutput("start_latency_arvalid", 32'(arValid), 32'd1);
      checkOutput("start_latency_araddr", arAddr, 32'h0000_6000);
      checkOutput("start_latency_arlen", 32'(arLen), 32'd1);
      for (int i = 0; i < 50; i++) begin
        if (pendR && hsTotal == 2) begin
          found = 1'b1;
          break;
        end
        @(negedge clk); #2;
      end
      checkOutput("final_beat_seen", 32'(found), 32'd1);
      checkOutput("done_before_final", 32'(done), 32'd0);
      @(negedge clk); #2;
      checkOutput("done_after_final", 32'(done), 32'd1);
      checkOutput("busy_after_final", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 7; i++) applyStimulus(i);

    // A start pulse while busy must be ignored.
    clearLogs();
    curCh = 2'd1;
    pulseStart(2'd1, 32'h0000_8000, 32'd4);
    @(negedge clk);
    start = 1'b1; chan = 2'd3; addr = 32'h0000_1002; len = 32'd0;
    @(negedge clk);
    start = 1'b0;
    waitIdle("ignore_start");
    checkOutput("ignore_start_done", 32'(done), 32'd1);
    checkOutput("ignore_start_error", 32'(error), 32'd0);
    checkOutput("ignore_start_ars", 32'(arAddrLog.size()), 32'd1);
    checkOutput("ignore_start_beats", 32'(chData.size()), 32'd4);

    // Watchdog: ARREADY held low.
    arReadyEn = 1'b0;
    clearLogs();
    curCh = 2'd0;
    @(negedge clk);
    pulseStart(2'd0, 32'h0000_7000, 32'd4);
    begin
      int stall = 0;
      #2;
      for (int i = 0; i < 100 && busy; i++) begin
        stall++;
        @(negedge clk); #2;
      end
      checkOutput("timeout_busy_cycles", 32'(stall), 32'd15);
      checkOutput("timeout_error", 32'(error), 32'd1);
      checkOutput("timeout_code", 32'(errCode), 32'd3);
      checkOutput("timeout_ars", 32'(arAddrLog.size()), 32'd0);
    end
    arReadyEn = 1'b1;

    // Reset in the middle of a burst aborts at once.
    clearLogs();
    curCh = 2'd2;
    @(negedge clk);
    pulseStart(2'd2, 32'h0000_9000, 32'd16);
    repeat (4) @(negedge clk);
    #2;
    checkOutput("midreset_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rready", 32'(rReady), 32'd0);
    checkOutput("midreset_valid", 32'(dataValid), 32'd0);
    checkOutput("midreset_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
